// File: rtl/rx_chk_pkg.sv
// Shared definitions for the per-port receive checker: header field
// offsets, error codes and FSM state encodings.
package rx_chk_pkg;

  // Error codes reported on err_code (0 = no error recorded yet)
  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_NO_SOP     = 3'd1;
  localparam logic [2:0] ERR_SOP_IN_PKT = 3'd2;
  localparam logic [2:0] ERR_SHORT      = 3'd3;
  localparam logic [2:0] ERR_LONG       = 3'd4;
  localparam logic [2:0] ERR_DEST       = 3'd5;
  localparam logic [2:0] ERR_DATA       = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  // Header layout, LSB first: dest | priority | length | 16-bit tag
  function automatic int hdr_prio_lsb(input int width_sel);
    return width_sel;
  endfunction

  function automatic int hdr_len_lsb(input int width_sel, input int width_prio);
    return width_sel + width_prio;
  endfunction

  function automatic int hdr_tag_lsb(input int width_sel, input int width_prio,
                                     input int width_len);
    return width_sel + width_prio + width_len;
  endfunction

endpackage

// File: rtl/recv_check_module.sv
// Receive-side packet checker for one switch port: parses the header,
// verifies payload length/content and reports completion and errors.
module recv_check_module
  import rx_chk_pkg::*;
#(
  parameter int PORT_NUB_TOTAL  = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int PRIORITY        = 8,
  parameter int DATA_LENGTH_MAX = 256,
  parameter int PORT_ID         = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rd_sop,
  input  logic                               rd_eop,
  input  logic                               rd_vld,
  input  logic [DATA_WIDTH-1:0]              rd_data,
  input  logic                               hold,
  output logic                               ready,
  output logic                               pkt_done,
  output logic                               pkt_error,
  output logic [2:0]                         err_code,
  output logic [$clog2(DATA_LENGTH_MAX)-1:0] pkt_length,
  output logic [$clog2(PRIORITY)-1:0]        pkt_priority,
  output logic [15:0]                        pkt_cnt,
  output logic [15:0]                        err_cnt
);

  localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);
  localparam int WIDTH_PRIORITY = $clog2(PRIORITY);
  localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX);
  localparam int PRIO_LSB       = hdr_prio_lsb(WIDTH_SEL);
  localparam int LEN_LSB        = hdr_len_lsb(WIDTH_SEL, WIDTH_PRIORITY);
  // One extra bit so the index can reach 'length' without wrapping
  localparam int IDX_W          = WIDTH_LENGTH + 1;

  rx_state_e                 state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [WIDTH_LENGTH-1:0]   hdr_len_q, hdr_len_d;
  logic [WIDTH_PRIORITY-1:0] hdr_prio_q, hdr_prio_d;
  logic                      ready_q;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic [2:0]                code_q, code_d;
  logic [WIDTH_LENGTH-1:0]   len_out_q, len_out_d;
  logic [WIDTH_PRIORITY-1:0] prio_out_q, prio_out_d;
  logic [15:0]               pkt_cnt_q, pkt_cnt_d;
  logic [15:0]               err_cnt_q, err_cnt_d;

  logic [WIDTH_SEL-1:0]      beat_dest;
  logic [WIDTH_PRIORITY-1:0] beat_prio;
  logic [WIDTH_LENGTH-1:0]   beat_len;
  logic                      dest_ok;
  logic                      data_ok;
  logic [IDX_W-1:0]          len_ext;
  logic                      take_hdr;
  logic                      sop_in_pkt;
  logic                      pkt_good;
  logic [2:0]                new_err;

  assign beat_dest = rd_data[WIDTH_SEL-1:0];
  assign beat_prio = rd_data[PRIO_LSB +: WIDTH_PRIORITY];
  assign beat_len  = rd_data[LEN_LSB +: WIDTH_LENGTH];
  assign dest_ok   = (beat_dest == WIDTH_SEL'(PORT_ID));
  assign data_ok   = (rd_data == DATA_WIDTH'(idx_q));
  assign len_ext   = {1'b0, hdr_len_q};

  // Ready is advisory only: a registered copy of the inverted hold request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= ~hold;
  end

  // Next-state, error classification and report generation for one beat
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hdr_len_d  = hdr_len_q;
    hdr_prio_d = hdr_prio_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    code_d     = code_q;
    len_out_d  = len_out_q;
    prio_out_d = prio_out_q;
    take_hdr   = 1'b0;
    sop_in_pkt = 1'b0;
    pkt_good   = 1'b0;
    new_err    = ERR_NONE;
    if (rd_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (rd_sop) take_hdr = 1'b1;
          else        new_err  = ERR_NO_SOP;
        end
        ST_BODY: begin
          if (rd_sop) begin
            take_hdr   = 1'b1;
            sop_in_pkt = 1'b1;
          end else if (idx_q == len_ext || !data_ok) begin
            // Overrun takes precedence; either way the rest is discarded
            new_err = (idx_q == len_ext) ? ERR_LONG : ERR_DATA;
            done_d  = rd_eop;
            state_d = rd_eop ? ST_IDLE : ST_DROP;
          end else if (rd_eop) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (idx_q == len_ext - IDX_W'(1)) pkt_good = 1'b1;
            else                              new_err  = ERR_SHORT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_DROP: begin
          if (rd_sop) begin
            take_hdr   = 1'b1;
            sop_in_pkt = 1'b1;
          end else if (rd_eop) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A sop beat always opens a new packet, whatever state it arrived in
      if (take_hdr) begin
        hdr_len_d  = beat_len;
        hdr_prio_d = beat_prio;
        idx_d      = '0;
        if (!dest_ok) begin
          new_err = ERR_DEST;
          done_d  = rd_eop;
          state_d = rd_eop ? ST_IDLE : ST_DROP;
        end else if (rd_eop) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (beat_len == '0) pkt_good = 1'b1;
          else                new_err  = ERR_SHORT;
        end else begin
          state_d = ST_BODY;
        end
      end

      // SOP_IN_PKT belongs to the aborted packet and wins the single report slot
      if (sop_in_pkt) begin
        error_d = 1'b1;
        code_d  = ERR_SOP_IN_PKT;
      end else if (new_err != ERR_NONE) begin
        error_d = 1'b1;
        code_d  = new_err;
      end

      if (done_d) begin
        len_out_d  = hdr_len_d;
        prio_out_d = hdr_prio_d;
      end
    end
    pkt_cnt_d = (pkt_good && pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    err_cnt_d = (error_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  // State, header and report registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      hdr_len_q  <= '0;
      hdr_prio_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= ERR_NONE;
      len_out_q  <= '0;
      prio_out_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hdr_len_q  <= hdr_len_d;
      hdr_prio_q <= hdr_prio_d;
      done_q     <= done_d;
      error_q    <= error_d;
      code_q     <= code_d;
      len_out_q  <= len_out_d;
      prio_out_q <= prio_out_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign ready        = ready_q;
  assign pkt_done     = done_q;
  assign pkt_error    = error_q;
  assign err_code     = code_q;
  assign pkt_length   = len_out_q;
  assign pkt_priority = prio_out_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_recv_check_module.sv
// Bench for recv_check_module: one checker per switch port, all fed the
// same read stream, checked against a packet-level expectation model.
module tb_recv_check_module;

  localparam int N = 8;

  typedef struct packed {
    logic        s;
    logic        e;
    logic [31:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_sop, rd_eop, rd_vld, hold;
  logic [31:0] rd_data;
  logic [N-1:0] ready_w, done_w, error_w;
  logic [2:0]  code_w [N];
  logic [7:0]  len_w  [N];
  logic [2:0]  prio_w [N];
  logic [15:0] pcnt_w [N];
  logic [15:0] ecnt_w [N];

  int checks = 0;
  int failures = 0;
  int m_pkt [N];
  int m_err [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_port
    recv_check_module #(
      .PORT_NUB_TOTAL(8), .DATA_WIDTH(32), .PRIORITY(8),
      .DATA_LENGTH_MAX(256), .PORT_ID(gi)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .rd_sop(rd_sop), .rd_eop(rd_eop),
      .rd_vld(rd_vld), .rd_data(rd_data), .hold(hold),
      .ready(ready_w[gi]), .pkt_done(done_w[gi]), .pkt_error(error_w[gi]),
      .err_code(code_w[gi]), .pkt_length(len_w[gi]),
      .pkt_priority(prio_w[gi]), .pkt_cnt(pcnt_w[gi]), .err_cnt(ecnt_w[gi])
    );
  end

  // Header word: dest[2:0] prio[5:3] len[13:6] tag[29:14]
  function automatic logic [31:0] mk_hdr(input int dest, input int prio,
                                         input int len, input int tag);
    return 32'(((tag & 32'hFFFF) << 14) | ((len & 255) << 6) |
               ((prio & 7) << 3) | (dest & 7));
  endfunction

  // Packet-level accounting: the addressed port sees the packet's own
  // outcome, every other port sees a destination error.
  task automatic model_packet(input int dest, input bit ok);
    for (int q = 0; q < N; q++) begin
      if (q == dest && ok) m_pkt[q]++;
      else                 m_err[q]++;
    end
  endtask

  task automatic model_all_err();
    for (int q = 0; q < N; q++) m_err[q]++;
  endtask

  task automatic drive_beat(input logic s, input logic e, input logic [31:0] d);
    rd_vld = 1'b1; rd_sop = s; rd_eop = e; rd_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0;
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = '0;
    for (int q = 0; q < N; q++) begin m_pkt[q] = 0; m_err[q] = 0; end
    repeat (2) @(posedge clk);
    #1;
    for (int q = 0; q < N; q++) begin
      checks++;
      if ({ready_w[q], done_w[q], error_w[q], code_w[q], len_w[q], prio_w[q],
           pcnt_w[q], ecnt_w[q]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs port=%0d got rdy=%0b done=%0b err=%0b code=%0d len=%0d prio=%0d pc=%0d ec=%0d exp all zero",
                 q, ready_w[q], done_w[q], error_w[q], code_w[q], len_w[q],
                 prio_w[q], pcnt_w[q], ecnt_w[q]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good();
    for (int b = 0; b <= 15; b++) begin
      if (b == 0) drive_beat(1'b1, 1'b0, mk_hdr(0, 3, 15, int'($urandom)));
      else        drive_beat(1'b0, b == 15, 32'(b - 1));
      checks++;
      if (error_w[0] !== 1'b0 || done_w[0] !== (b == 15)) begin
        failures++;
        $display("FAIL good_beat b=%0d got done=%0b err=%0b exp done=%0b err=0",
                 b, done_w[0], error_w[0], b == 15);
      end
      if (b == 0) begin
        checks++;
        if (error_w[1] !== 1'b1 || code_w[1] !== 3'd5) begin
          failures++;
          $display("FAIL good_other_dest got err=%0b code=%0d exp err=1 code=5",
                   error_w[1], code_w[1]);
        end
      end
    end
    model_packet(0, 1'b1);
    checks++;
    if (len_w[0] !== 8'd15 || prio_w[0] !== 3'd3 || pcnt_w[0] !== 16'(m_pkt[0]) ||
        ecnt_w[0] !== 16'(m_err[0])) begin
      failures++;
      $display("FAIL good_result got len=%0d prio=%0d pc=%0d ec=%0d exp len=15 prio=3 pc=%0d ec=%0d",
               len_w[0], prio_w[0], pcnt_w[0], ecnt_w[0], m_pkt[0], m_err[0]);
    end
    idle_cycles(1);
    checks++;
    if (done_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL good_done_pulse got done=%0b exp 0", done_w[0]);
    end
  endtask

  task automatic test_zero_len();
    drive_beat(1'b1, 1'b1, mk_hdr(0, 2, 0, 16'h1234));
    model_packet(0, 1'b1);
    checks++;
    if (done_w[0] !== 1'b1 || error_w[0] !== 1'b0 || pcnt_w[0] !== 16'(m_pkt[0]) ||
        len_w[0] !== 8'd0 || prio_w[0] !== 3'd2) begin
      failures++;
      $display("FAIL zero_len got done=%0b err=%0b pc=%0d len=%0d prio=%0d exp done=1 err=0 pc=%0d len=0 prio=2",
               done_w[0], error_w[0], pcnt_w[0], len_w[0], prio_w[0], m_pkt[0]);
    end
    checks++;
    if (done_w[2] !== 1'b1 || error_w[2] !== 1'b1 || code_w[2] !== 3'd5) begin
      failures++;
      $display("FAIL zero_len_other got done=%0b err=%0b code=%0d exp done=1 err=1 code=5",
               done_w[2], error_w[2], code_w[2]);
    end
    drive_beat(1'b1, 1'b1, mk_hdr(0, 1, 5, 16'h0042));
    model_packet(0, 1'b0);
    checks++;
    if (done_w[0] !== 1'b1 || error_w[0] !== 1'b1 || code_w[0] !== 3'd3 ||
        pcnt_w[0] !== 16'(m_pkt[0]) || len_w[0] !== 8'd5) begin
      failures++;
      $display("FAIL short_hdr got done=%0b err=%0b code=%0d pc=%0d len=%0d exp done=1 err=1 code=3 pc=%0d len=5",
               done_w[0], error_w[0], code_w[0], pcnt_w[0], len_w[0], m_pkt[0]);
    end
    idle_cycles(1);
  endtask

  task automatic test_dest();
    for (int b = 0; b <= 4; b++) begin
      if (b == 0) drive_beat(1'b1, 1'b0, mk_hdr(1, 6, 4, 16'hBEEF));
      else        drive_beat(1'b0, b == 4, 32'(b - 1));
      checks++;
      if (error_w[0] !== (b == 0) || (b == 0 && code_w[0] !== 3'd5) ||
          done_w[0] !== (b == 4) || error_w[1] !== 1'b0 || done_w[1] !== (b == 4)) begin
        failures++;
        $display("FAIL dest_beat b=%0d got p0 err=%0b code=%0d done=%0b p1 err=%0b done=%0b exp p0 err=%0b code=5 done=%0b p1 err=0",
                 b, error_w[0], code_w[0], done_w[0], error_w[1], done_w[1], b == 0, b == 4);
      end
    end
    model_packet(1, 1'b1);
    checks++;
    if (pcnt_w[0] !== 16'(m_pkt[0]) || ecnt_w[0] !== 16'(m_err[0]) ||
        pcnt_w[1] !== 16'(m_pkt[1])) begin
      failures++;
      $display("FAIL dest_counts got p0 pc=%0d ec=%0d p1 pc=%0d exp %0d %0d %0d",
               pcnt_w[0], ecnt_w[0], pcnt_w[1], m_pkt[0], m_err[0], m_pkt[1]);
    end
    idle_cycles(1);
  endtask

  task automatic test_corrupt();
    logic [31:0] w;
    // corrupted payload word
    for (int b = 0; b <= 8; b++) begin
      w = (b == 3) ? 32'h55 : 32'(b - 1);
      if (b == 0) drive_beat(1'b1, 1'b0, mk_hdr(0, 1, 8, 16'h0007));
      else        drive_beat(1'b0, b == 8, w);
      checks++;
      if (error_w[0] !== (b == 3) || (b == 3 && code_w[0] !== 3'd6) ||
          done_w[0] !== (b == 8)) begin
        failures++;
        $display("FAIL data_beat b=%0d got err=%0b code=%0d done=%0b exp err=%0b code=6 done=%0b",
                 b, error_w[0], code_w[0], done_w[0], b == 3, b == 8);
      end
    end
    model_packet(0, 1'b0);
    // sop inside a packet: old one aborted, new one completes
    for (int b = 0; b <= 7; b++) begin
      if (b == 0)      drive_beat(1'b1, 1'b0, mk_hdr(0, 4, 6, 16'h0001));
      else if (b == 4) drive_beat(1'b1, 1'b0, mk_hdr(0, 5, 3, 16'h0002));
      else if (b < 4)  drive_beat(1'b0, 1'b0, 32'(b - 1));
      else             drive_beat(1'b0, b == 7, 32'(b - 5));
      checks++;
      if (error_w[0] !== (b == 4) || (b == 4 && code_w[0] !== 3'd2) ||
          done_w[0] !== (b == 7) || (b == 4 && (error_w[3] !== 1'b1 || code_w[3] !== 3'd2))) begin
        failures++;
        $display("FAIL sop_in_pkt b=%0d got err=%0b code=%0d done=%0b p3 err=%0b code=%0d exp err=%0b code=2 done=%0b",
                 b, error_w[0], code_w[0], done_w[0], error_w[3], code_w[3], b == 4, b == 7);
      end
    end
    model_all_err();
    model_packet(0, 1'b1);
    checks++;
    if (prio_w[0] !== 3'd5 || len_w[0] !== 8'd3 || pcnt_w[0] !== 16'(m_pkt[0]) ||
        ecnt_w[0] !== 16'(m_err[0])) begin
      failures++;
      $display("FAIL sop_in_pkt_result got prio=%0d len=%0d pc=%0d ec=%0d exp prio=5 len=3 pc=%0d ec=%0d",
               prio_w[0], len_w[0], pcnt_w[0], ecnt_w[0], m_pkt[0], m_err[0]);
    end
    // stray beat while idle
    idle_cycles(1);
    drive_beat(1'b0, 1'($urandom_range(0, 1)), $urandom);
    model_all_err();
    for (int q = 0; q < N; q++) begin
      checks++;
      if (error_w[q] !== 1'b1 || code_w[q] !== 3'd1 || done_w[q] !== 1'b0) begin
        failures++;
        $display("FAIL no_sop port=%0d got err=%0b code=%0d done=%0b exp err=1 code=1 done=0",
                 q, error_w[q], code_w[q], done_w[q]);
      end
    end
    idle_cycles(1);
  endtask

  task automatic test_overrun();
    for (int b = 0; b <= 5; b++) begin
      if (b == 0) drive_beat(1'b1, 1'b0, mk_hdr(0, 2, 3, 16'h0003));
      else        drive_beat(1'b0, b == 5, 32'(b - 1));
      checks++;
      if (error_w[0] !== (b == 4) || (b == 4 && code_w[0] !== 3'd4) ||
          done_w[0] !== (b == 5)) begin
        failures++;
        $display("FAIL long_beat b=%0d got err=%0b code=%0d done=%0b exp err=%0b code=4 done=%0b",
                 b, error_w[0], code_w[0], done_w[0], b == 4, b == 5);
      end
    end
    model_packet(0, 1'b0);
    drive_beat(1'b1, 1'b0, mk_hdr(0, 0, 1, 16'h0004));
    drive_beat(1'b0, 1'b1, 32'd0);
    model_packet(0, 1'b1);
    checks++;
    if (done_w[0] !== 1'b1 || error_w[0] !== 1'b0 || pcnt_w[0] !== 16'(m_pkt[0])) begin
      failures++;
      $display("FAIL long_recover got done=%0b err=%0b pc=%0d exp done=1 err=0 pc=%0d",
               done_w[0], error_w[0], pcnt_w[0], m_pkt[0]);
    end
    idle_cycles(1);
  endtask

  task automatic test_backpressure();
    logic exp_old;
    for (int i = 0; i < 16; i++) begin
      exp_old = ~hold;
      hold = (i % 3 == 0) ? ~hold : 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (ready_w !== {N{exp_old}}) begin
        failures++;
        $display("FAIL ready_latency i=%0d got=%b exp=%b", i, ready_w, {N{exp_old}});
      end
      @(posedge clk); #1;
      checks++;
      if (ready_w !== {N{~hold}}) begin
        failures++;
        $display("FAIL ready_follow i=%0d got=%b exp=%b", i, ready_w, {N{~hold}});
      end
    end
    hold = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random_back_to_back();
    beat_t bq[$];
    int dest, prio, len, kind, n, j, err_beat, last, obs;
    logic [2:0] exp_code;
    for (int p = 0; p < 40; p++) begin
      bq.delete();
      dest = $urandom_range(0, N - 1);
      prio = $urandom_range(0, 7);
      len  = $urandom_range(0, 12);
      kind = $urandom_range(0, 3);
      if ((kind == 1 || kind == 2) && len == 0) len = 1;
      err_beat = -1;
      exp_code = 3'd0;
      case (kind)
        0: begin
          bq.push_back('{1'b1, len == 0, mk_hdr(dest, prio, len, p)});
          for (int k = 0; k < len; k++) bq.push_back('{1'b0, k == len - 1, 32'(k)});
        end
        1: begin
          n = $urandom_range(0, len - 1);
          bq.push_back('{1'b1, n == 0, mk_hdr(dest, prio, len, p)});
          for (int k = 0; k < n; k++) bq.push_back('{1'b0, k == n - 1, 32'(k)});
          err_beat = n; exp_code = 3'd3;
        end
        2: begin
          j = $urandom_range(0, len - 1);
          bq.push_back('{1'b1, 1'b0, mk_hdr(dest, prio, len, p)});
          for (int k = 0; k < len; k++)
            bq.push_back('{1'b0, k == len - 1,
                           (k == j) ? (32'(k) ^ (32'd1 << $urandom_range(0, 31))) : 32'(k)});
          err_beat = j + 1; exp_code = 3'd6;
        end
        default: begin
          n = len + $urandom_range(1, 3);
          bq.push_back('{1'b1, 1'b0, mk_hdr(dest, prio, len, p)});
          for (int k = 0; k < n; k++) bq.push_back('{1'b0, k == n - 1, 32'(k)});
          err_beat = len + 1; exp_code = 3'd4;
        end
      endcase
      last = bq.size() - 1;
      obs = (dest + 1) % N;
      for (int b = 0; b <= last; b++) begin
        drive_beat(bq[b].s, bq[b].e, bq[b].d);
        checks++;
        if (error_w[dest] !== (b == err_beat) || (b == err_beat && code_w[dest] !== exp_code) ||
            done_w[dest] !== (b == last)) begin
          failures++;
          $display("FAIL rand_target pkt=%0d kind=%0d b=%0d got err=%0b code=%0d done=%0b exp err=%0b code=%0d done=%0b",
                   p, kind, b, error_w[dest], code_w[dest], done_w[dest],
                   b == err_beat, exp_code, b == last);
        end
        checks++;
        if (error_w[obs] !== (b == 0) || (b == 0 && code_w[obs] !== 3'd5) ||
            done_w[obs] !== (b == last)) begin
          failures++;
          $display("FAIL rand_other pkt=%0d b=%0d got err=%0b code=%0d done=%0b exp err=%0b code=5 done=%0b",
                   p, b, error_w[obs], code_w[obs], done_w[obs], b == 0, b == last);
        end
      end
      model_packet(dest, kind == 0);
      checks++;
      if (len_w[dest] !== 8'(len) || prio_w[dest] !== 3'(prio) ||
          pcnt_w[dest] !== 16'(m_pkt[dest]) || ecnt_w[dest] !== 16'(m_err[dest])) begin
        failures++;
        $display("FAIL rand_result pkt=%0d got len=%0d prio=%0d pc=%0d ec=%0d exp len=%0d prio=%0d pc=%0d ec=%0d",
                 p, len_w[dest], prio_w[dest], pcnt_w[dest], ecnt_w[dest],
                 len, prio, m_pkt[dest], m_err[dest]);
      end
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(1);
  endtask

  task automatic test_counters();
    for (int q = 0; q < N; q++) begin
      checks++;
      if (pcnt_w[q] !== 16'(m_pkt[q]) || ecnt_w[q] !== 16'(m_err[q])) begin
        failures++;
        $display("FAIL counters port=%0d got pc=%0d ec=%0d exp pc=%0d ec=%0d",
                 q, pcnt_w[q], ecnt_w[q], m_pkt[q], m_err[q]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_beat(1'b1, 1'b0, mk_hdr(0, 1, 10, 16'h0055));
    for (int k = 0; k < 3; k++) drive_beat(1'b0, 1'b0, 32'(k));
    rst_n = 1'b0;
    #1;
    for (int q = 0; q < N; q++) begin
      checks++;
      if ({ready_w[q], done_w[q], error_w[q], code_w[q], len_w[q], prio_w[q],
           pcnt_w[q], ecnt_w[q]} !== '0) begin
        failures++;
        $display("FAIL reset_mid port=%0d got pc=%0d ec=%0d code=%0d rdy=%0b exp all zero",
                 q, pcnt_w[q], ecnt_w[q], code_w[q], ready_w[q]);
      end
    end
    for (int q = 0; q < N; q++) begin m_pkt[q] = 0; m_err[q] = 0; end
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_beat(1'b1, 1'b0, mk_hdr(0, 7, 2, 16'h0066));
    drive_beat(1'b0, 1'b0, 32'd0);
    drive_beat(1'b0, 1'b1, 32'd1);
    model_packet(0, 1'b1);
    checks++;
    if (done_w[0] !== 1'b1 || error_w[0] !== 1'b0 || pcnt_w[0] !== 16'(m_pkt[0]) ||
        prio_w[0] !== 3'd7 || len_w[0] !== 8'd2) begin
      failures++;
      $display("FAIL reset_mid_after got done=%0b err=%0b pc=%0d prio=%0d len=%0d exp done=1 err=0 pc=%0d prio=7 len=2",
               done_w[0], error_w[0], pcnt_w[0], prio_w[0], len_w[0], m_pkt[0]);
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_good();
    test_zero_len();
    test_dest();
    test_corrupt();
    test_overrun();
    test_backpressure();
    test_random_back_to_back();
    test_counters();
    test_reset_mid();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recv_check_module.md
# recv_check_module

Per-port packet receiver and checker on the read side of `top_nxn`. It is the counterpart of `send_module` and consumes one port's `rd_sop`/`rd_eop`/`rd_vld`/`rd_data` stream. It parses the header word, counts and checks the payload, and reports per-packet completion and errors. It drives the port's `ready` toward the switch, so the bench can apply backpressure.

## Interface
- `PORT_NUB_TOTAL`, 8: number of switch ports.
- `DATA_WIDTH`, 32: width of one data beat.
- `PRIORITY`, 8: number of priority levels.
- `DATA_LENGTH_MAX`, 256: exclusive upper bound on payload length.
- `PORT_ID`, 0: index of the port this instance terminates.
- Derived widths: `WIDTH_SEL` = $clog2(PORT_NUB_TOTAL), `WIDTH_PRIORITY` = $clog2(PRIORITY), `WIDTH_LENGTH` = $clog2(DATA_LENGTH_MAX).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rd_sop`  in  1  first beat of a packet (header).
- `rd_eop`  in  1  last beat of a packet.
- `rd_vld`  in  1  beat valid.
- `rd_data`  in  DATA_WIDTH  beat data.
- `hold`  in  1  bench backpressure request.
- `ready`  out  1  to switch; registered `~hold`.
- `pkt_done`  out  1  one-cycle pulse when a packet ends.
- `pkt_error`  out  1  one-cycle pulse when an error is detected.
- `err_code`  out  3  code of the latest error, held until the next error.
- `pkt_length`  out  WIDTH_LENGTH  header length of the last completed packet.
- `pkt_priority`  out  WIDTH_PRIORITY  priority of the last completed packet.
- `pkt_cnt`  out  16  good packets, saturating.
- `err_cnt`  out  16  errors, saturating.

## Operation
- Header beat (`rd_sop` & `rd_vld`), LSB first:
  - dest [WIDTH_SEL-1:0]
  - priority (next WIDTH_PRIORITY bits)
  - length (next WIDTH_LENGTH bits)
  - 16-bit tag
  - upper bits ignored
- Payload: exactly `length` beats follow the header. Payload word k (k = 0..length-1) equals k zero-extended. `rd_eop` is set on the header if length = 0, otherwise on payload word length-1.
- Every beat with `rd_vld` = 1 is accepted regardless of `ready`; `ready` is advisory only.
- FSM:
  - IDLE: sop beat -> BODY, or stays in IDLE if sop & eop arrive on the same beat.
  - BODY: expected eop -> IDLE.
  - DROP: discards beats until eop -> IDLE.
- Error codes:
  - 1 NO_SOP: a beat without sop in IDLE. One error per beat; stays in IDLE.
  - 2 SOP_IN_PKT: sop in BODY or DROP. Error for the old packet; the beat is parsed as a new header.
  - 3 SHORT: eop before `length` payload words -> IDLE.
  - 4 LONG: payload word index = length without eop -> DROP.
  - 5 DEST: header dest ≠ PORT_ID -> DROP, or IDLE if the header also carries eop.
  - 6 DATA: payload mismatch -> DROP, or IDLE on eop.
- Error reporting:
  - At most one error per packet (first detected). DROP reports nothing further except SOP_IN_PKT.
  - `pkt_done` pulses on every packet end: good, SHORT, or an errored packet closing in DROP.
  - `pkt_cnt` increments only for error-free packets.
- Simultaneous `pkt_done` and `pkt_error` pulses are allowed.

## Timing
- Reset values:
  - `ready` = 0, `pkt_done` = 0, `pkt_error` = 0, `err_code` = 0
  - `pkt_length` = 0, `pkt_priority` = 0, `pkt_cnt` = 0, `err_cnt` = 0
  - FSM in IDLE
- `ready` follows `hold` with 1-cycle latency.
- `pkt_done`, `pkt_error`, `err_code`, `pkt_length`, `pkt_priority` and the counters update in the cycle after the triggering beat.
- Back-to-back packets (sop the cycle after eop) run at full rate with no bubble.
- Reset mid-packet aborts the packet silently; the next beat is treated from IDLE.
- Counters saturate at 16'hFFFF.
- The payload index counter is WIDTH_LENGTH+1 bits, so the LONG check cannot wrap.

## Structure
- Shared package `rx_chk_pkg` holds:
  - header field offset functions derived from the parameters
  - the 3-bit error-code constants (ERR_NONE = 0 through ERR_DATA = 6)
  - FSM state encodings
- No sub-module: a single FSM with an index counter and a header register.
- Instantiate one instance per port in the bench's generate loop, with `PORT_ID` = i.

## Test plan
- Good packet: header dest = PORT_ID, priority 3, length 15, words 0..14, eop on word 14 -> `pkt_done` one cycle after eop; `pkt_length` = 15, `pkt_priority` = 3, `pkt_cnt` = 1, no error.
- Zero-length packet: sop & eop on one beat with length 0 -> `pkt_done`, `pkt_cnt` +1. Repeat with length 5 -> SHORT (code 3).
- Dest mismatch: dest = PORT_ID+1, length 4 -> code 5 one cycle after the header; the remaining beats are dropped; `pkt_done` on eop; `pkt_cnt` unchanged; `err_cnt` = 1.
- Corruption: word 2 = 0x55 in a length-8 packet -> code 6. A sop mid-packet -> code 2 and the new packet completes good. A stray vld in IDLE -> code 1.
- Overrun: length 3 with no eop on word 2 -> code 4 at word index 3; state returns to IDLE on the later eop.
- Backpressure and reset: toggling `hold` -> `ready` mirrors it one cycle later. Assert `rst_n` low mid-packet -> all outputs go to zero immediately; a subsequent good packet passes.
